// File: rtl/prefix_add_pkg.sv
// Shared types and constants for the limb-serial prefix-adder sequencer.
package prefix_add_pkg;

  localparam int OPCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prefix_add_seq_if.sv
// Operand request port and result port of the sequencer, both valid/ready.
interface prefix_add_seq_if #(
  parameter int N = 16
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/prefix_add_limb.sv
// Combinational LIMB_W-bit Sklansky prefix adder; cin is folded into the bit-0
// generate term so the prefix tree delivers carries that already include it.
module prefix_add_limb #(
  parameter int LIMB_W = 4
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  localparam int LEVELS = (LIMB_W > 1) ? $clog2(LIMB_W) : 0;

  logic [LIMB_W-1:0] w_p0;
  logic [LIMB_W-1:0] w_g0;
  logic [LIMB_W-1:0] w_gf;
  logic [LIMB_W:0]   w_c;

  assign w_p0 = a ^ b;
  assign w_g0 = (a & b) | LIMB_W'(w_p0[0] & cin);

  // After level l, node i covers bits [(i>>(l+1))<<(l+1) .. i]; the group
  // propagate of a node is just the AND of its bit propagates.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    logic [LIMB_W-1:0] w_gi;
    logic [LIMB_W-1:0] w_go;

    if (l == 0) begin : g_first
      assign w_gi = w_g0;
    end else begin : g_next
      assign w_gi = g_lvl[l-1].w_go;
    end

    for (genvar i = 0; i < LIMB_W; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_cmb
        localparam int LO = (i >> l) << l;
        assign w_go[i] = w_gi[i] | ((&w_p0[i:LO]) & w_gi[LO-1]);
      end else begin : g_pass
        assign w_go[i] = w_gi[i];
      end
    end
  end

  if (LEVELS == 0) begin : g_flat
    assign w_gf = w_g0;
  end else begin : g_tree
    assign w_gf = g_lvl[LEVELS-1].w_go;
  end

  assign w_c  = {w_gf, cin};
  assign sum  = w_p0 ^ w_c[LIMB_W-1:0];
  assign cout = w_c[LIMB_W];

endmodule

// File: rtl/prefix_add_seq.sv
// Wide adder built from one narrow prefix slice reused once per cycle,
// least-significant limb first, with the carry chained through a register.
module prefix_add_seq
  import prefix_add_pkg::*;
#(
  parameter int LIMB_W = 4,
  parameter int LIMBS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  prefix_add_seq_if.slave    bus,
  output logic               busy,
  output logic [OPCNT_W-1:0] op_count
);

  localparam int N     = LIMB_W * LIMBS;
  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_sum;
  logic [N-1:0]       w_sum_nxt;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [OPCNT_W-1:0] r_op_count;
  logic [LIMB_W-1:0]  w_s;
  logic               w_c;

  prefix_add_limb #(.LIMB_W(LIMB_W)) u_limb (
    .a    (r_a[LIMB_W-1:0]),
    .b    (r_b[LIMB_W-1:0]),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_c)
  );

  // New limb enters at the top so that after LIMBS shifts limb 0 sits at the bottom.
  if (LIMBS == 1) begin : g_one
    assign w_sum_nxt = w_s;
  end else begin : g_many
    assign w_sum_nxt = {w_s, r_sum[N-1:LIMB_W]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)                     w_state_nxt = RUN;
      RUN:     if (r_idx == IDX_W'(LIMBS - 1))       w_state_nxt = DONE;
      DONE:    if (bus.out_ready)                    w_state_nxt = IDLE;
      default:                                       w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too so an aborted operation leaves
    // no stale sum, carry or count visible afterwards.
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_op_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a     <= bus.in_a;
          r_b     <= bus.in_b;
          r_carry <= bus.in_cin;
          r_idx   <= '0;
        end
        RUN: begin
          r_sum   <= w_sum_nxt;
          r_a     <= r_a >> LIMB_W;
          r_b     <= r_b >> LIMB_W;
          r_carry <= w_c;
          r_idx   <= r_idx + 1'b1;
        end
        DONE: if (bus.out_ready) r_op_count <= r_op_count + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_carry;
  assign busy          = (r_state != IDLE);
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_prefix_add_seq.sv
// Directed bench for prefix_add_seq: a 4x4-limb instance and a single-limb instance.
module tb_prefix_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefix_add_seq_if #(.N(16)) bus0 ();
  prefix_add_seq_if #(.N(4))  bus1 ();

  logic        busy0, busy1;
  logic [15:0] cnt0, cnt1;

  prefix_add_seq #(.LIMB_W(4), .LIMBS(4)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .op_count(cnt0)
  );

  prefix_add_seq #(.LIMB_W(4), .LIMBS(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .op_count(cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept/result monitor for the back-to-back phase.
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          acc_cyc[$];
  logic [15:0] res_sum[$];
  logic        res_cout[$];

  always @(posedge clk) begin
    if (mon_en) begin
      if (bus0.in_valid && bus0.in_ready) acc_cyc.push_back(cyc);
      if (bus0.out_valid && bus0.out_ready) begin
        res_sum.push_back(bus0.out_sum);
        res_cout.push_back(bus0.out_cout);
      end
    end
    cyc++;
  end

  // Operands are scrambled right after acceptance to prove they were latched.
  task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     output logic [15:0] s, output logic c, output int lat);
    int w;
    // NOTE: bench inputs change with blocking assignments 1 time unit after the
    // edge, so the DUT always samples settled values.
    bus0.in_a = a; bus0.in_b = b; bus0.in_cin = cin; bus0.in_valid = 1'b1;
    w = 0;
    while (!bus0.in_ready && w < 20) begin tick(); w++; end
    tick();
    bus0.in_valid = 1'b0; bus0.in_a = ~a; bus0.in_b = ~b; bus0.in_cin = ~cin;
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin tick(); lat++; end
    s = bus0.out_sum; c = bus0.out_cout;
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     output logic [3:0] s, output logic c, output int lat);
    int w;
    bus1.in_a = a; bus1.in_b = b; bus1.in_cin = cin; bus1.in_valid = 1'b1;
    w = 0;
    while (!bus1.in_ready && w < 20) begin tick(); w++; end
    tick();
    bus1.in_valid = 1'b0; bus1.in_a = ~a; bus1.in_b = ~b; bus1.in_cin = ~cin;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin tick(); lat++; end
    s = bus1.out_sum; c = bus1.out_cout;
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
  } vec_t;

  vec_t vecs [5] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1},
    '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1},
    '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1},
    '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0}
  };

  vec_t bb [3] = '{
    '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0}
  };

  initial begin
    logic [15:0] s;
    logic [3:0]  s1;
    logic        c;
    int          lat;
    int          w;
    int          k;
    int          exp_cnt;

    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_cin = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b0;
    tick();
    tick();

    check("rst_in_ready",  bus0.in_ready,  1);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_busy",      busy0,          0);
    check("rst_out_sum",   bus0.out_sum,   0);
    check("rst_out_cout",  bus0.out_cout,  0);
    check("rst_op_count",  cnt0,           0);
    check("rst1_in_ready", bus1.in_ready,  1);
    check("rst1_op_count", cnt1,           0);
    rst = 1'b0;
    tick();

    exp_cnt = 0;
    foreach (vecs[i]) begin
      op0(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
      exp_cnt++;
      check($sformatf("vec%0d_sum", i),  s,    vecs[i].s);
      check($sformatf("vec%0d_cout", i), c,    vecs[i].c);
      check($sformatf("vec%0d_lat", i),  lat,  4);
      check($sformatf("vec%0d_cnt", i),  cnt0, exp_cnt);
    end

    // Result held under back-pressure while a new request waits.
    bus0.in_a = 16'h00FF; bus0.in_b = 16'h0001; bus0.in_cin = 1'b0; bus0.in_valid = 1'b1;
    tick();
    bus0.in_a = 16'hDEAD; bus0.in_b = 16'hBEEF; bus0.in_cin = 1'b1;
    w = 0;
    while (!bus0.out_valid && w < 20) begin tick(); w++; end
    check("hold_lat", w, 4);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), bus0.out_valid, 1);
      check($sformatf("hold%0d_sum", i),   bus0.out_sum,   16'h0100);
      check($sformatf("hold%0d_cout", i),  bus0.out_cout,  0);
      check($sformatf("hold%0d_ready", i), bus0.in_ready,  0);
      tick();
    end
    bus0.out_ready = 1'b1; bus0.in_valid = 1'b0;
    tick();
    bus0.out_ready = 1'b0;
    exp_cnt++;
    check("hold_cnt",      cnt0,          exp_cnt);
    check("hold_idle",     bus0.in_ready, 1);
    check("hold_busy_off", busy0,         0);

    // Reset while the slice is on limb 2.
    bus0.in_a = 16'h1111; bus0.in_b = 16'h1111; bus0.in_cin = 1'b0; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", busy0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready",  bus0.in_ready,  1);
    check("mid_rst_out_valid", bus0.out_valid, 0);
    check("mid_rst_op_count",  cnt0,           0);
    exp_cnt = 0;
    op0(16'h0001, 16'h0001, 1'b0, s, c, lat);
    exp_cnt++;
    check("post_rst_sum",  s,    16'h0002);
    check("post_rst_cout", c,    0);
    check("post_rst_lat",  lat,  4);
    check("post_rst_cnt",  cnt0, exp_cnt);

    // Back-to-back with in_valid and out_ready held high.
    acc_cyc.delete(); res_sum.delete(); res_cout.delete();
    mon_en = 1'b1;
    bus0.out_ready = 1'b1;
    k = 0;
    bus0.in_a = bb[0].a; bus0.in_b = bb[0].b; bus0.in_cin = bb[0].cin; bus0.in_valid = 1'b1;
    for (int t = 0; t < 60 && res_sum.size() < 3; t++) begin
      tick();
      if (acc_cyc.size() > k) begin
        k++;
        if (k < 3) begin
          bus0.in_a = bb[k].a; bus0.in_b = bb[k].b; bus0.in_cin = bb[k].cin;
        end else begin
          bus0.in_valid = 1'b0; bus0.in_a = 16'hBEEF; bus0.in_b = 16'hCAFE; bus0.in_cin = 1'b1;
        end
      end
    end
    mon_en = 1'b0;
    bus0.out_ready = 1'b0;
    check("bb_accepts", acc_cyc.size(), 3);
    check("bb_results", res_sum.size(), 3);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("bb_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 6);
    for (int i = 0; i < res_sum.size() && i < 3; i++) begin
      check($sformatf("bb%0d_sum", i),  res_sum[i],  bb[i].s);
      check($sformatf("bb%0d_cout", i), res_cout[i], bb[i].c);
    end
    exp_cnt += 3;
    check("bb_cnt", cnt0, exp_cnt);

    // Single-limb instance, with the counter preloaded to its wrap point.
    force u1.r_op_count = 16'hFFFF;
    tick();
    release u1.r_op_count;
    op1(4'hF, 4'h1, 1'b1, s1, c, lat);
    check("l1_sum",  s1,   4'h1);
    check("l1_cout", c,    1);
    check("l1_lat",  lat,  1);
    check("l1_wrap", cnt1, 16'h0000);
    op1(4'h3, 4'h4, 1'b0, s1, c, lat);
    check("l1b_sum",  s1,   4'h7);
    check("l1b_cout", c,    0);
    check("l1b_lat",  lat,  1);
    check("l1b_cnt",  cnt1, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
